// File: rtl/tmr_alarm_sched.sv
// tmr_alarm_sched: multi-slot alarm scheduler sharing one timebase and one
// comparator across NUM_SLOT alarms. Expired alarms are delivered one at a
// time over a valid/ready event port with round-robin fairness.
// Optional feature macro: TMR_SCHED_PERIODIC_EN (periodic reload + overrun).
module tmr_alarm_sched #(
  parameter  int NUM_SLOT  = 4,
  parameter  int CNT_WIDTH = 32,
  localparam int ID_W      = $clog2(NUM_SLOT)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 arm_valid_i,
  output logic                 arm_ready_o,
  input  logic [ID_W-1:0]      arm_id_i,
  input  logic [CNT_WIDTH-1:0] arm_dly_i,
  input  logic                 arm_per_i,
  input  logic                 cancel_i,
  input  logic [ID_W-1:0]      cancel_id_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [ID_W-1:0]      evt_id_o,
  output logic [NUM_SLOT-1:0]  busy_o,
  output logic [NUM_SLOT-1:0]  ovr_o,
  output logic [CNT_WIDTH-1:0] now_o,
  output logic                 irq_o
);

  // Modular elapsed-time test: correct across timebase wrap as long as the
  // delay leaves headroom for the scan latency.
  function automatic logic slot_due(input logic [CNT_WIDTH-1:0] now,
                                    input logic [CNT_WIDTH-1:0] start,
                                    input logic [CNT_WIDTH-1:0] dly);
    logic [CNT_WIDTH-1:0] elapsed;
    elapsed = now - start;
    return (elapsed >= dly);
  endfunction

  logic [CNT_WIDTH-1:0] now_q;
  logic [CNT_WIDTH-1:0] dly_q   [NUM_SLOT];
  logic [CNT_WIDTH-1:0] start_q [NUM_SLOT];
  logic [NUM_SLOT-1:0]  busy_q, pend_q, ovr_q;
  logic [NUM_SLOT-1:0]  busy_d, pend_d, ovr_d;
  logic [NUM_SLOT-1:0]  pend_avail;
  logic [ID_W-1:0]      scan_ptr_q, rr_ptr_q, evt_id_q;
  logic [ID_W-1:0]      win_id, rr_idx;
  logic                 evt_valid_q, win_found;
  logic                 arm_hs, evt_hs, scan_cancel, scan_exp, scan_reload;

`ifdef TMR_SCHED_PERIODIC_EN
  logic [NUM_SLOT-1:0]  per_q;
  assign scan_reload = scan_exp & per_q[scan_ptr_q];
  assign ovr_o       = ovr_q;

  // Per-slot periodic flag, captured on the arm handshake
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      per_q <= '0;
    end else if (arm_hs) begin
      per_q[arm_id_i] <= arm_per_i;
    end
  end
`else
  logic unused_arm_per;
  assign unused_arm_per = arm_per_i;
  assign scan_reload    = 1'b0;
  assign ovr_o          = '0;
`endif

  // arm_ready looks at registered busy, so arm and cancel of one busy slot
  // can never land in the same cycle.
  assign arm_ready_o = ~busy_q[arm_id_i];
  assign arm_hs      = arm_valid_i & arm_ready_o;
  assign evt_hs      = evt_valid_q & evt_ready_i;
  assign scan_cancel = cancel_i && (cancel_id_i == scan_ptr_q);
  assign scan_exp    = busy_q[scan_ptr_q] && !scan_cancel &&
                       slot_due(now_q, start_q[scan_ptr_q], dly_q[scan_ptr_q]);

  assign evt_valid_o = evt_valid_q;
  assign irq_o       = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign busy_o      = busy_q;
  assign now_o       = now_q;

  // Next busy/pend/ovr: handshake clears, expiry sets, cancel overrides, arm sets busy
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (evt_hs) begin
      pend_d[evt_id_q] = 1'b0;
      ovr_d[evt_id_q]  = 1'b0;
    end
    if (scan_exp) begin
      if (scan_reload) begin
        // A pend being consumed this cycle is not an overrun
        if (pend_q[scan_ptr_q] && !(evt_hs && (evt_id_q == scan_ptr_q)))
          ovr_d[scan_ptr_q] = 1'b1;
        else
          pend_d[scan_ptr_q] = 1'b1;
      end else begin
        busy_d[scan_ptr_q] = 1'b0;
        pend_d[scan_ptr_q] = 1'b1;
      end
    end
    if (cancel_i) begin
      busy_d[cancel_id_i] = 1'b0;
      pend_d[cancel_id_i] = 1'b0;
      ovr_d[cancel_id_i]  = 1'b0;
    end
    if (arm_hs) begin
      busy_d[arm_id_i] = 1'b1;
    end
  end

  // Round-robin pick: first pending slot at or after rr_ptr, skipping one being cancelled
  always_comb begin
    pend_avail = pend_q;
    if (cancel_i) pend_avail[cancel_id_i] = 1'b0;
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      rr_idx = rr_ptr_q + ID_W'(i);
      if (!win_found && pend_avail[rr_idx]) begin
        win_found = 1'b1;
        win_id    = rr_idx;
      end
    end
  end

  // Timebase, scan pointer and per-slot flag registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      now_q      <= '0;
      scan_ptr_q <= '0;
      busy_q     <= '0;
      pend_q     <= '0;
      ovr_q      <= '0;
    end else begin
      if (tick_i) now_q <= now_q + CNT_WIDTH'(1);
      scan_ptr_q <= scan_ptr_q + ID_W'(1);
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
    end
  end

  // Slot delay/start storage: loaded on arm, start advanced on periodic reload
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_SLOT; i++) begin
        dly_q[i]   <= '0;
        start_q[i] <= '0;
      end
    end else begin
      if (arm_hs) begin
        dly_q[arm_id_i]   <= arm_dly_i;
        start_q[arm_id_i] <= tick_i ? now_q + CNT_WIDTH'(1) : now_q;
      end
      if (scan_reload) begin
        start_q[scan_ptr_q] <= start_q[scan_ptr_q] + dly_q[scan_ptr_q];
      end
    end
  end

  // Event port: hold the presented winner until consumed, then gap one cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else if (evt_hs) begin
      evt_valid_q <= 1'b0;
      rr_ptr_q    <= evt_id_q + ID_W'(1);
    end else if (!evt_valid_q && win_found) begin
      evt_valid_q <= 1'b1;
      evt_id_q    <= win_id;
    end
  end

endmodule

// File: tb/tb_tmr_alarm_sched.sv
// Bench for tmr_alarm_sched: directed scenarios followed by random traffic,
// all compared each cycle against a tick-count reference model.
module tb_tmr_alarm_sched;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int IW = 2;
`ifdef TMR_SCHED_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          tick_i, arm_valid_i, arm_ready_o, arm_per_i, cancel_i;
  logic [IW-1:0] arm_id_i, cancel_id_i, evt_id_o;
  logic [CW-1:0] arm_dly_i, now_o;
  logic          evt_valid_o, evt_ready_i, irq_o;
  logic [N-1:0]  busy_o, ovr_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: slot age is kept as a plain count of ticks since arm
  int           m_now, m_scan, m_rr, m_id;
  bit           m_valid;
  logic [N-1:0] m_busy, m_pend, m_ovr, m_per;
  int           m_el [N];
  int           m_dly [N];
  int           got_ids [4];
  int           got_n;

  tmr_alarm_sched #(.NUM_SLOT(N), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .tick_i(tick_i),
    .arm_valid_i(arm_valid_i), .arm_ready_o(arm_ready_o), .arm_id_i(arm_id_i),
    .arm_dly_i(arm_dly_i), .arm_per_i(arm_per_i), .cancel_i(cancel_i),
    .cancel_id_i(cancel_id_i), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_id_o(evt_id_o), .busy_o(busy_o), .ovr_o(ovr_o), .now_o(now_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_now = 0; m_scan = 0; m_rr = 0; m_id = 0; m_valid = 1'b0;
    m_busy = '0; m_pend = '0; m_ovr = '0; m_per = '0;
    for (int i = 0; i < N; i++) begin
      m_el[i] = 0;
      m_dly[i] = 0;
    end
  endtask

  task automatic check_outputs();
    chk("now", now_o, m_now);
    chk("busy", busy_o, m_busy);
    chk("evt_valid", evt_valid_o, m_valid);
    chk("irq", irq_o, m_valid);
    if (m_valid) chk("evt_id", evt_id_o, m_id);
    chk("ovr", ovr_o, m_ovr);
    chk("arm_ready", arm_ready_o, !m_busy[arm_id_i]);
  endtask

  task automatic idle();
    tick_i = 1'b0; arm_valid_i = 1'b0; arm_per_i = 1'b0;
    cancel_i = 1'b0; evt_ready_i = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic cycle();
    logic [N-1:0] nb, np, no, avail;
    int  s, w;
    bit  due, ehs, ahs, found;
    @(posedge clk);
    s   = m_scan;
    ehs = m_valid && evt_ready_i;
    ahs = arm_valid_i && !m_busy[arm_id_i];
    due = m_busy[s] && (m_el[s] >= m_dly[s]) && !(cancel_i && int'(cancel_id_i) == s);
    nb = m_busy; np = m_pend; no = m_ovr;
    if (ehs) begin np[m_id] = 1'b0; no[m_id] = 1'b0; end
    if (due) begin
      if (PER_EN && m_per[s]) begin
        m_el[s] -= m_dly[s];
        if (m_pend[s] && !(ehs && m_id == s)) no[s] = 1'b1;
        else np[s] = 1'b1;
      end else begin
        nb[s] = 1'b0;
        np[s] = 1'b1;
      end
    end
    if (cancel_i) begin
      nb[cancel_id_i] = 1'b0; np[cancel_id_i] = 1'b0; no[cancel_id_i] = 1'b0;
    end
    if (tick_i) for (int i = 0; i < N; i++) m_el[i]++;
    if (ahs) begin
      nb[arm_id_i] = 1'b1; m_dly[arm_id_i] = arm_dly_i;
      m_el[arm_id_i] = 0; m_per[arm_id_i] = arm_per_i;
    end
    avail = m_pend;
    if (cancel_i) avail[cancel_id_i] = 1'b0;
    if (ehs) begin
      m_valid = 1'b0;
      m_rr = (m_id + 1) % N;
    end else if (!m_valid) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        w = (m_rr + k) % N;
        if (!found && avail[w]) begin found = 1'b1; m_id = w; end
      end
      m_valid = found;
    end
    m_busy = nb; m_pend = np; m_ovr = no;
    if (tick_i) m_now = (m_now + 1) % (1 << CW);
    m_scan = (m_scan + 1) % N;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    idle();
    rst_n_i = 1'b0;
    #2;
    model_reset();
    chk("rst_now", now_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_evt_valid", evt_valid_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_evt_id", evt_id_o, 0);
    chk("rst_ovr", ovr_o, 0);
    chk("rst_arm_ready", arm_ready_o, 1);
    @(posedge clk);
    #3;
    rst_n_i = 1'b1;
  endtask

  task automatic arm_slot(input int id, input int dly, input bit per, input bit tk);
    arm_valid_i = 1'b1; arm_id_i = IW'(id); arm_dly_i = CW'(dly);
    arm_per_i = per; tick_i = tk;
    cycle();
    idle();
  endtask

  // Consume cnt events with ready held high, recording their IDs in order
  task automatic collect(input int cnt);
    got_n = 0;
    for (int i = 0; i < 4; i++) got_ids[i] = -1;
    evt_ready_i = 1'b1;
    for (int k = 0; k < 16 && got_n < cnt; k++) begin
      if (evt_valid_o) begin
        got_ids[got_n] = evt_id_o;
        got_n++;
      end
      cycle();
    end
    evt_ready_i = 1'b0;
    chk("collect_count", got_n, cnt);
  endtask

  initial begin
    int ev;
    rst_n_i = 1'b1;
    idle();
    arm_id_i = '0; arm_dly_i = '0; cancel_id_i = '0;
    #1;
    do_reset();

    // One-shot: slot 2, dly 5, tick every third cycle
    arm_slot(2, 5, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      cycle(); cycle();
      tick_i = 1'b1; cycle(); tick_i = 1'b0;
    end
    for (int k = 0; k < N + 1 && !evt_valid_o; k++) cycle();
    chk("oneshot_valid", evt_valid_o, 1);
    chk("oneshot_id", evt_id_o, 2);
    chk("oneshot_busy2", busy_o[2], 0);
    collect(1);

    // Fairness from rr_ptr = 0
    do_reset();
    arm_slot(0, 1, 1'b0, 1'b0);
    arm_slot(1, 1, 1'b0, 1'b0);
    arm_slot(3, 1, 1'b0, 1'b0);
    for (int k = 0; k < N && m_scan != N - 1; k++) cycle();
    tick_i = 1'b1; cycle(); tick_i = 1'b0;
    for (int k = 0; k < 12 && m_pend != 4'b1011; k++) cycle();
    collect(3);
    chk("fair_a0", got_ids[0], 0);
    chk("fair_a1", got_ids[1], 1);
    chk("fair_a2", got_ids[2], 3);
    // Move rr_ptr to 1, then repeat
    arm_slot(0, 0, 1'b0, 1'b0);
    collect(1);
    chk("fair_mid", got_ids[0], 0);
    arm_slot(0, 1, 1'b0, 1'b0);
    arm_slot(1, 1, 1'b0, 1'b0);
    arm_slot(3, 1, 1'b0, 1'b0);
    for (int k = 0; k < N && m_scan != 0; k++) cycle();
    tick_i = 1'b1; cycle(); tick_i = 1'b0;
    for (int k = 0; k < 12 && m_pend != 4'b1011; k++) cycle();
    collect(3);
    chk("fair_b0", got_ids[0], 1);
    chk("fair_b1", got_ids[1], 3);
    chk("fair_b2", got_ids[2], 0);

    // Wrap-around: now = 254, dly 4 fires at now = 2
    do_reset();
    tick_i = 1'b1;
    for (int k = 0; k < 254; k++) cycle();
    tick_i = 1'b0;
    chk("wrap_preload", now_o, 254);
    arm_slot(1, 4, 1'b0, 1'b0);
    ev = 0;
    for (int t = 0; t < 3; t++) begin
      tick_i = 1'b1; cycle(); tick_i = 1'b0;
      for (int k = 0; k < N + 1; k++) begin
        cycle();
        if (evt_valid_o) ev++;
      end
    end
    chk("wrap_early", ev, 0);
    tick_i = 1'b1; cycle(); tick_i = 1'b0;
    for (int k = 0; k < N + 1 && !evt_valid_o; k++) cycle();
    chk("wrap_valid", evt_valid_o, 1);
    chk("wrap_id", evt_id_o, 1);
    chk("wrap_now", now_o, 2);
    collect(1);

    // Cancel in the very cycle the scan visits an expired slot 1
    do_reset();
    arm_slot(1, 0, 1'b0, 1'b0);
    for (int k = 0; k < N && m_scan != 1; k++) cycle();
    cancel_i = 1'b1; cancel_id_i = 2'd1; cycle(); cancel_i = 1'b0;
    ev = 0;
    for (int k = 0; k < 2 * N; k++) begin
      cycle();
      if (evt_valid_o) ev++;
    end
    chk("race_no_evt", ev, 0);
    chk("race_busy1", busy_o[1], 0);

    // Periodic reload and overrun
    do_reset();
`ifdef TMR_SCHED_PERIODIC_EN
    arm_slot(0, 2, 1'b1, 1'b1);
    tick_i = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    tick_i = 1'b0;
    chk("per_ovr_set", ovr_o[0], 1);
    chk("per_busy", busy_o[0], 1);
    chk("per_valid", evt_valid_o, 1);
    evt_ready_i = 1'b1; cycle(); evt_ready_i = 1'b0;
    chk("per_ovr_clr", ovr_o[0], 0);
    tick_i = 1'b1; cycle(); cycle(); tick_i = 1'b0;
    for (int k = 0; k < 2 * N && !evt_valid_o; k++) cycle();
    chk("per_next_valid", evt_valid_o, 1);
    chk("per_next_id", evt_id_o, 0);
    cancel_i = 1'b1; cancel_id_i = 2'd0; cycle(); cancel_i = 1'b0;
    chk("per_cancel_busy", busy_o[0], 0);
    evt_ready_i = 1'b1; cycle(); evt_ready_i = 1'b0;
`else
    arm_slot(0, 2, 1'b1, 1'b1);
    tick_i = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    tick_i = 1'b0;
    for (int k = 0; k < 2 * N && !evt_valid_o; k++) cycle();
    chk("oneonly_valid", evt_valid_o, 1);
    chk("oneonly_id", evt_id_o, 0);
    chk("oneonly_busy", busy_o[0], 0);
    chk("oneonly_ovr", ovr_o, 0);
    collect(1);
`endif

    // Arm a busy slot: refused, slot keeps its long delay
    do_reset();
    arm_slot(3, 50, 1'b0, 1'b0);
    arm_valid_i = 1'b1; arm_id_i = 2'd3; arm_dly_i = 8'd1;
    cycle();
    chk("armbusy_ready", arm_ready_o, 0);
    chk("armbusy_busy3", busy_o[3], 1);
    idle();
    ev = 0;
    tick_i = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    tick_i = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      cycle();
      if (evt_valid_o) ev++;
    end
    chk("armbusy_no_evt", ev, 0);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick_i      = ($urandom_range(0, 4) == 0);
      arm_valid_i = ($urandom_range(0, 2) == 0);
      arm_id_i    = IW'($urandom_range(0, N - 1));
      arm_dly_i   = CW'($urandom_range(0, 15));
      arm_per_i   = 1'($urandom_range(0, 1));
      cancel_i    = ($urandom_range(0, 7) == 0);
      cancel_id_i = IW'($urandom_range(0, N - 1));
      evt_ready_i = 1'($urandom_range(0, 1));
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
